// File: rtl/receptor_uart_param_if.sv
// receptor_uart_param_if
// Receive-side byte bus between the UART receiver and the byte consumer
// (command decoder / FIFO).
//   rx_dv      one-cycle strobe: rx_byte and both error flags are valid
//   rx_byte    received data, bit 0 = first data bit on the line
//   parity_err parity mismatch on the last frame
//   frame_err  a stop bit was sampled low on the last frame
//   busy       receiver is in the middle of a frame
// Modports: master = receiver (drives), slave = consumer (reads).
interface receptor_uart_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_dv;
    logic [DATA_BITS-1:0] rx_byte;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output rx_dv,
        output rx_byte,
        output parity_err,
        output frame_err,
        output busy
    );

    modport slave (
        input rx_dv,
        input rx_byte,
        input parity_err,
        input frame_err,
        input busy
    );
endinterface

// File: rtl/receptor_uart_param.sv
// receptor_uart_param
// Parametrised UART receiver: 5..9 data bits, none/odd/even parity, 1 or 2
// stop bits. Each bit is decided by a 3-sample majority vote at the end of
// the bit period (which, after the half-bit start alignment, sits at the bit
// centre).
// Parameters: CLKS_PER_BIT (>= 4), DATA_BITS (5..9), PARITY (0 none, 1 odd,
//             2 even), STOP_BITS (1 or 2).
// Ports:
//   i_Clock      single clock, rising edge
//   i_Reset      asynchronous, active-high reset
//   i_Rx_Serial  asynchronous serial line, idle high, LSB first
//   rx_bus       master side of receptor_uart_param_if (byte, flags, busy)
module receptor_uart_param #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                         i_Clock,
    input  logic                         i_Reset,
    input  logic                         i_Rx_Serial,
    receptor_uart_param_if.master        rx_bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF      = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] SAMP0_CNT = CNT_W'(CLKS_PER_BIT - 3);
    localparam logic [CNT_W-1:0] SAMP1_CNT = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_CLEANUP   = 3'd5,
        ST_WAIT_HIGH = 3'd6
    } state_t;

    state_t               state;
    state_t               state_next;

    logic                 rx_meta;
    logic                 sync;
    logic [CNT_W-1:0]     count;
    logic [IDX_W-1:0]     bit_idx;
    logic                 samp0;
    logic                 samp1;
    logic [DATA_BITS-1:0] data_reg;
    logic                 parity_err_q;
    logic                 frame_err_q;

    logic                 dv_q;
    logic [DATA_BITS-1:0] byte_q;
    logic                 parity_out_q;
    logic                 frame_out_q;

    logic                 bit_done;
    logic                 majority;
    logic                 frame_done;
    logic                 busy_c;

    // Two-flop synchroniser; both flops reset to the idle (high) level so a
    // reset never looks like a start bit.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            rx_meta <= 1'b1;
            sync    <= 1'b1;
        end else begin
            rx_meta <= i_Rx_Serial;
            sync    <= rx_meta;
        end
    end

    // The third vote is the live synchronised value at the last count.
    assign bit_done = (count == LAST_CNT);
    assign majority = (samp0 & samp1) | (samp0 & sync) | (samp1 & sync);

    // State register.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (!sync) state_next = ST_START;
            end
            ST_START: begin
                if (count == HALF) state_next = sync ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (bit_done && (bit_idx == LAST_DATA))
                    state_next = (PARITY != 0) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (bit_done) state_next = ST_STOP;
            end
            ST_STOP: begin
                if (bit_done && (bit_idx == LAST_STOP)) state_next = ST_CLEANUP;
            end
            ST_CLEANUP: begin
                state_next = sync ? ST_IDLE : ST_WAIT_HIGH;
            end
            ST_WAIT_HIGH: begin
                if (sync) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        busy_c     = (state != ST_IDLE);
        frame_done = (state == ST_STOP) && bit_done && (bit_idx == LAST_STOP);
    end

    // Datapath: bit timing counter, vote samples, data shift register and
    // per-frame error terms. Data shifts in from the top so the first bit
    // received ends up in bit 0. bit_idx is reused to count stop bits.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            count        <= '0;
            bit_idx      <= '0;
            samp0        <= 1'b1;
            samp1        <= 1'b1;
            data_reg     <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            dv_q         <= 1'b0;
            byte_q       <= '0;
            parity_out_q <= 1'b0;
            frame_out_q  <= 1'b0;
        end else begin
            dv_q <= frame_done;
            case (state)
                ST_IDLE: begin
                    count   <= '0;
                    bit_idx <= '0;
                    if (!sync) begin
                        parity_err_q <= 1'b0;
                        frame_err_q  <= 1'b0;
                    end
                end
                ST_START: begin
                    bit_idx <= '0;
                    count   <= (count == HALF) ? '0 : count + 1'b1;
                end
                ST_DATA, ST_PARITY, ST_STOP: begin
                    if (count == SAMP0_CNT) samp0 <= sync;
                    if (count == SAMP1_CNT) samp1 <= sync;
                    if (!bit_done) begin
                        count <= count + 1'b1;
                    end else begin
                        count <= '0;
                        if (state == ST_DATA) begin
                            data_reg <= {majority, data_reg[DATA_BITS-1:1]};
                            bit_idx  <= (bit_idx == LAST_DATA) ? '0 : bit_idx + 1'b1;
                        end else if (state == ST_PARITY) begin
                            // Odd parity requires the XOR over data and parity to be 1.
                            if (PARITY == 1)
                                parity_err_q <= ~(^data_reg ^ majority);
                            else
                                parity_err_q <= ^data_reg ^ majority;
                        end else begin
                            if (!majority) frame_err_q <= 1'b1;
                            if (bit_idx == LAST_STOP) begin
                                bit_idx      <= '0;
                                byte_q       <= data_reg;
                                parity_out_q <= parity_err_q;
                                frame_out_q  <= frame_err_q | ~majority;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    count   <= '0;
                    bit_idx <= '0;
                end
            endcase
        end
    end

    assign rx_bus.rx_dv      = dv_q;
    assign rx_bus.rx_byte    = byte_q;
    assign rx_bus.parity_err = parity_out_q;
    assign rx_bus.frame_err  = frame_out_q;
    assign rx_bus.busy       = busy_c;
endmodule

// File: tb/tb_receptor_uart_param.sv
// tb_receptor_uart_param
// Drives two receivers from one clock: dut_a is 8N1, dut_b is 7 data bits,
// even parity, 2 stop bits, both at 16 clocks per bit. Each frame sent
// queues the byte, flags and strobe cycle it must produce; one compare
// process checks both receivers against those queues every cycle.
`timescale 1ns/1ps
module tb_receptor_uart_param;
    localparam int CPB    = 16;
    localparam int H      = (CPB - 1) / 2;
    localparam int A_BITS = 8;
    localparam int A_PAR  = 0;
    localparam int A_STOP = 1;
    localparam int B_BITS = 7;
    localparam int B_PAR  = 2;
    localparam int B_STOP = 2;

    typedef struct {
        int         cycle;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic i_Clock = 1'b0;
    logic i_Reset = 1'b1;
    logic rx_a    = 1'b1;
    logic rx_b    = 1'b1;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    exp_t       exp_q_a[$];
    exp_t       exp_q_b[$];
    logic [8:0] held_byte [2];
    logic       held_perr [2];
    logic       held_ferr [2];
    int         last_t0     [2];
    int         last_dv_cyc [2];
    logic [8:0] last_dv_byte[2];
    logic       last_dv_perr[2];
    logic       last_dv_ferr[2];
    int         dv_count    [2];

    always #5 i_Clock = ~i_Clock;
    always @(posedge i_Clock) cyc <= cyc + 1;

    receptor_uart_param_if #(.DATA_BITS(A_BITS)) bus_a ();
    receptor_uart_param_if #(.DATA_BITS(B_BITS)) bus_b ();

    receptor_uart_param #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(A_BITS), .PARITY(A_PAR), .STOP_BITS(A_STOP)
    ) dut_a (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .i_Rx_Serial(rx_a),
        .rx_bus     (bus_a.master)
    );

    receptor_uart_param #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(B_BITS), .PARITY(B_PAR), .STOP_BITS(B_STOP)
    ) dut_b (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .i_Rx_Serial(rx_b),
        .rx_bus     (bus_b.master)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic checkWindow(input string name, input int actual,
                               input int expected, input int tol);
        tests++;
        if (actual < expected - tol || actual > expected + tol) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, required %0d +/- %0d", name, actual, expected, tol);
        end
    endtask

    // Model: frame length, strobe cycle and parity outcome from the frame rules.
    function automatic int frame_len(input int bits, input int par, input int stop);
        return 1 + bits + ((par != 0) ? 1 : 0) + stop;
    endfunction

    function automatic int dv_cycle(input int t0, input int n);
        return t0 + 3 + H + (n - 1) * CPB;
    endfunction

    function automatic int ones_in(input logic [8:0] data, input int bits);
        int ones = 0;
        for (int i = 0; i < bits; i++) ones += int'(data[i]);
        return ones;
    endfunction

    function automatic logic correct_parity(input logic [8:0] data, input int bits, input int par);
        int ones = ones_in(data, bits);
        if (par == 1) return (ones % 2 == 0);
        return (ones % 2 == 1);
    endfunction

    function automatic logic parity_fails(input logic [8:0] data, input int bits,
                                          input int par, input logic pbit);
        int ones = ones_in(data, bits) + int'(pbit);
        if (par == 1) return (ones % 2 == 0);
        if (par == 2) return (ones % 2 == 1);
        return 1'b0;
    endfunction

    task automatic set_line(input int which, input logic v);
        if (which == 0) rx_a = v;
        else            rx_b = v;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge i_Clock);
        #1;
    endtask

    task automatic idle(input int which, input int n);
        set_line(which, 1'b1);
        wait_cycles(n);
    endtask

    // Sends one frame starting now (caller sits 1 ns after a rising edge) and
    // queues the outcome. The line is left at the last stop bit's level.
    // glitch_bit >= 0 inverts the line for one cycle at glitch_off into that bit.
    task automatic applyStimulus(input int which, input logic [8:0] data,
                                 input logic flip_par, input logic [1:0] stop_vals,
                                 input int glitch_bit, input int glitch_off);
        int          bits = (which == 0) ? A_BITS : B_BITS;
        int          par  = (which == 0) ? A_PAR  : B_PAR;
        int          stop = (which == 0) ? A_STOP : B_STOP;
        int          len  = frame_len(bits, par, stop);
        int          idx  = 1;
        logic [15:0] frame = '0;
        logic        pbit = 1'b0;
        exp_t        e;
        frame[0] = 1'b0;
        for (int i = 0; i < bits; i++) frame[1+i] = data[i];
        idx = 1 + bits;
        if (par != 0) begin
            pbit = correct_parity(data, bits, par) ^ flip_par;
            frame[idx] = pbit;
            idx++;
        end
        e.ferr = 1'b0;
        for (int j = 0; j < stop; j++) begin
            frame[idx+j] = stop_vals[j];
            if (!stop_vals[j]) e.ferr = 1'b1;
        end
        e.data = '0;
        for (int i = 0; i < bits; i++) e.data[i] = data[i];
        e.perr  = parity_fails(data, bits, par, pbit);
        last_t0[which] = cyc + 1;
        e.cycle = dv_cycle(cyc + 1, len);
        if (which == 0) exp_q_a.push_back(e);
        else            exp_q_b.push_back(e);
        for (int b = 0; b < len; b++) begin
            set_line(which, frame[b]);
            if (b == glitch_bit) begin
                wait_cycles(glitch_off);
                set_line(which, ~frame[b]);
                wait_cycles(1);
                set_line(which, frame[b]);
                wait_cycles(CPB - glitch_off - 1);
            end else begin
                wait_cycles(CPB);
            end
        end
    endtask

    task automatic check_dut(input int which, input logic dv, input logic [8:0] byte_v,
                             input logic perr, input logic ferr);
        string p = (which == 0) ? "A" : "B";
        exp_t  e;
        int    have = (which == 0) ? exp_q_a.size() : exp_q_b.size();
        if (have > 0) e = (which == 0) ? exp_q_a[0] : exp_q_b[0];
        if (dv) begin
            dv_count[which]++;
            last_dv_cyc[which]  = cyc;
            last_dv_byte[which] = byte_v;
            last_dv_perr[which] = perr;
            last_dv_ferr[which] = ferr;
            if (have == 0) begin
                checkOutput({p, "_unexpected_dv"}, 32'(dv), 32'h0);
            end else begin
                if (which == 0) void'(exp_q_a.pop_front());
                else            void'(exp_q_b.pop_front());
                checkWindow({p, "_dv_cycle"}, cyc, e.cycle, 1);
                checkOutput({p, "_byte"}, 32'(byte_v), 32'(e.data));
                checkOutput({p, "_parity_err"}, 32'(perr), 32'(e.perr));
                checkOutput({p, "_frame_err"}, 32'(ferr), 32'(e.ferr));
                held_byte[which] = e.data;
                held_perr[which] = e.perr;
                held_ferr[which] = e.ferr;
            end
        end else begin
            if (have > 0 && cyc > e.cycle + 1) begin
                checkOutput({p, "_missing_dv"}, 32'(dv), 32'h1);
                if (which == 0) void'(exp_q_a.pop_front());
                else            void'(exp_q_b.pop_front());
            end
            checkOutput({p, "_hold_byte"}, 32'(byte_v), 32'(held_byte[which]));
            checkOutput({p, "_hold_perr"}, 32'(perr), 32'(held_perr[which]));
            checkOutput({p, "_hold_ferr"}, 32'(ferr), 32'(held_ferr[which]));
        end
    endtask

    // Single compare process: reset values while reset is high, otherwise
    // strobes against the expectation queues and held values between strobes.
    always @(negedge i_Clock) begin
        if (i_Reset) begin
            checkOutput("A_rst_dv",   32'(bus_a.rx_dv), 32'h0);
            checkOutput("A_rst_byte", 32'(bus_a.rx_byte), 32'h0);
            checkOutput("A_rst_busy", 32'(bus_a.busy), 32'h0);
            checkOutput("B_rst_dv",   32'(bus_b.rx_dv), 32'h0);
            checkOutput("B_rst_byte", 32'(bus_b.rx_byte), 32'h0);
            checkOutput("B_rst_busy", 32'(bus_b.busy), 32'h0);
            for (int k = 0; k < 2; k++) begin
                held_byte[k] = '0;
                held_perr[k] = 1'b0;
                held_ferr[k] = 1'b0;
            end
            exp_q_a.delete();
            exp_q_b.delete();
        end else begin
            check_dut(0, bus_a.rx_dv, {1'b0, bus_a.rx_byte}, bus_a.parity_err, bus_a.frame_err);
            check_dut(1, bus_b.rx_dv, {2'b00, bus_b.rx_byte}, bus_b.parity_err, bus_b.frame_err);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            dv_count[k] = 0;
            last_t0[k] = 0;
            last_dv_cyc[k] = 0;
            last_dv_byte[k] = '0;
            last_dv_perr[k] = 1'b0;
            last_dv_ferr[k] = 1'b0;
        end
        i_Reset = 1'b1;
        wait_cycles(5);
        checkOutput("A_reset_frame_err", 32'(bus_a.frame_err), 32'h0);
        checkOutput("B_reset_parity_err", 32'(bus_b.parity_err), 32'h0);
        i_Reset = 1'b0;
        wait_cycles(4);

        // 8N1 0xA5, ideal waveform; strobe 154 cycles after first low sample.
        applyStimulus(0, 9'h0A5, 1'b0, 2'b11, -1, 0);
        idle(0, 3 * CPB);
        checkOutput("A_a5_byte_lit", 32'(last_dv_byte[0]), 32'h0A5);
        checkOutput("A_a5_ferr_lit", 32'(last_dv_ferr[0]), 32'h0);
        checkWindow("A_a5_latency_lit", last_dv_cyc[0] - last_t0[0], 154, 1);
        checkOutput("A_a5_dv_count", 32'(dv_count[0]), 32'd1);

        // 7E2 0x55: correct parity, then flipped parity; strobe at +170.
        applyStimulus(1, 9'h055, 1'b0, 2'b11, -1, 0);
        idle(1, 3 * CPB);
        checkOutput("B_55_byte_lit", 32'(last_dv_byte[1]), 32'h055);
        checkOutput("B_55_perr_lit", 32'(last_dv_perr[1]), 32'h0);
        checkWindow("B_55_latency_lit", last_dv_cyc[1] - last_t0[1], 170, 1);
        applyStimulus(1, 9'h055, 1'b1, 2'b11, -1, 0);
        idle(1, 3 * CPB);
        checkOutput("B_55_flip_byte_lit", 32'(last_dv_byte[1]), 32'h055);
        checkOutput("B_55_flip_perr_lit", 32'(last_dv_perr[1]), 32'h1);

        // Stop bit low, then line stuck low for 40 bit times: one strobe only.
        applyStimulus(0, 9'h00F, 1'b0, 2'b10, -1, 0);
        wait_cycles(20 * CPB);
        checkOutput("A_stuck_busy", 32'(bus_a.busy), 32'h1);
        wait_cycles(20 * CPB);
        checkOutput("A_stuck_dv_count", 32'(dv_count[0]), 32'd2);
        checkOutput("A_stuck_ferr_lit", 32'(last_dv_ferr[0]), 32'h1);
        checkOutput("A_stuck_byte_lit", 32'(last_dv_byte[0]), 32'h00F);
        idle(0, 4);
        checkOutput("A_release_busy", 32'(bus_a.busy), 32'h0);
        wait_cycles(2 * CPB);

        // 5-cycle start glitch is rejected.
        set_line(0, 1'b0);
        wait_cycles(5);
        idle(0, 3 * CPB);
        checkOutput("A_glitch_busy", 32'(bus_a.busy), 32'h0);
        checkOutput("A_glitch_dv_count", 32'(dv_count[0]), 32'd2);

        // One-cycle low glitch at the centre of data bit 3 of 0xFF.
        applyStimulus(0, 9'h0FF, 1'b0, 2'b11, 4, CPB / 2);
        idle(0, 3 * CPB);
        checkOutput("A_ff_byte_lit", 32'(last_dv_byte[0]), 32'h0FF);

        // Back-to-back frames, no idle gap.
        applyStimulus(0, 9'h03C, 1'b0, 2'b11, -1, 0);
        applyStimulus(0, 9'h0C3, 1'b0, 2'b11, -1, 0);
        idle(0, 3 * CPB);
        checkOutput("A_b2b_byte_lit", 32'(last_dv_byte[0]), 32'h0C3);
        checkOutput("A_b2b_dv_count", 32'(dv_count[0]), 32'd5);

        // Asynchronous reset in the middle of a data bit.
        set_line(0, 1'b0);
        wait_cycles(CPB);
        set_line(0, 1'b0);
        wait_cycles(CPB / 2);
        #2 i_Reset = 1'b1;
        #1;
        checkOutput("A_async_rst_dv",   32'(bus_a.rx_dv), 32'h0);
        checkOutput("A_async_rst_byte", 32'(bus_a.rx_byte), 32'h0);
        checkOutput("A_async_rst_perr", 32'(bus_a.parity_err), 32'h0);
        checkOutput("A_async_rst_ferr", 32'(bus_a.frame_err), 32'h0);
        checkOutput("A_async_rst_busy", 32'(bus_a.busy), 32'h0);
        set_line(0, 1'b1);
        wait_cycles(2);
        i_Reset = 1'b0;
        wait_cycles(4);
        applyStimulus(0, 9'h081, 1'b0, 2'b11, -1, 0);
        idle(0, 3 * CPB);
        checkOutput("A_81_byte_lit", 32'(last_dv_byte[0]), 32'h081);
        checkOutput("A_81_ferr_lit", 32'(last_dv_ferr[0]), 32'h0);

        checkOutput("A_pending_frames", 32'(exp_q_a.size()), 32'h0);
        checkOutput("B_pending_frames", 32'(exp_q_b.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/receptor_uart_param.md
# receptor_uart_param

Parametrised UART receiver, successor to the fixed 8N1 receiver. Supports 5–9 data bits, none/odd/even parity, and 1 or 2 stop bits. Each bit is decided by a 3-sample majority vote near the bit centre, and the block reports parity and framing errors. It sits between the pad-side serial input and the byte-consuming logic (command decoder / FIFO) in the transmitter-receiver design.

## Interface
- CLKS_PER_BIT, 87, clock cycles per bit = f(i_Clock)/baud; legal ≥ 4
- DATA_BITS, 8, data bits per frame; legal 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, 1 or 2
- i_Clock  in  1  single clock; all logic on rising edge
- i_Reset  in  1  asynchronous, active-high reset
- i_Rx_Serial  in  1  asynchronous serial line, idle high, LSB first
- o_Rx_DV  out  1  one-cycle strobe: frame complete, o_Rx_Byte and error flags valid
- o_Rx_Byte  out  DATA_BITS  received data, bit 0 = first data bit received
- o_Parity_Err  out  1  parity mismatch on last frame; always 0 when PARITY = 0
- o_Frame_Err  out  1  any stop bit sampled low on last frame
- o_Busy  out  1  high whenever the FSM is not in IDLE

## Operation
- Input synchroniser: 2-flop chain; both flops reset to 1. The FSM uses only the second flop (`sync`).
- H = (CLKS_PER_BIT-1)/2 (integer division). The bit counter is wide enough for CLKS_PER_BIT-1.
- FSM states and transitions:
  - IDLE: clears the counter and bit index. Moves to START when `sync` = 0.
  - START: increments the counter until it reaches H. At count H, if `sync` = 0, clears the counter and goes to DATA; if `sync` = 1, returns to IDLE (glitch rejected, no DV).
  - DATA, PARITY, STOP: each bit period the counter runs 0..CLKS_PER_BIT-1. `sync` is sampled at counts CLKS_PER_BIT-3, -2 and -1. At count CLKS_PER_BIT-1 the bit value is the majority of the 3 samples, and the counter returns to 0.
    - DATA: writes the bit to index 0..DATA_BITS-1. After the last data bit, goes to PARITY if PARITY ≠ 0, else STOP.
    - PARITY: computes the parity error. Odd parity: XOR of data bits and parity bit must be 1. Even parity: it must be 0.
    - STOP: handles STOP_BITS periods. A low majority in either stop bit sets the frame error. At the end of the last stop period: loads o_Rx_Byte, o_Parity_Err and o_Frame_Err, pulses o_Rx_DV, and goes to CLEANUP.
  - CLEANUP: lasts one cycle. Goes to IDLE if `sync` = 1. If `sync` = 0, goes to WAIT_HIGH.
  - WAIT_HIGH: stays until `sync` = 1, then goes to IDLE. This prevents a break or stuck-low line from producing repeated frames.
- Output holding: o_Rx_Byte and both error flags change only on the o_Rx_DV cycle and hold until the next DV. Data and flags are delivered even when an error is flagged.
- Error accumulation: per-frame error terms are cleared on entry to START.
- Unused encodings: undefined state encodings go to IDLE.

## Timing
- Reset values: o_Rx_DV = 0, o_Rx_Byte = 0, o_Parity_Err = 0, o_Frame_Err = 0, o_Busy = 0. FSM = IDLE, counters = 0, synchroniser = 1.
- Reset mid-frame: the frame is discarded and no DV is produced. After release, a low line is treated as a new start bit after 2 cycles.
- Latency: let t0 be the edge at which i_Rx_Serial is first sampled low, and N = 1 (start) + DATA_BITS + (PARITY ≠ 0) + STOP_BITS. o_Rx_DV is high for exactly one cycle at t0 + 3 + H + (N-1)·CLKS_PER_BIT (bench tolerance ±1).
- Back-to-back frames: a start bit immediately following the stop bit is accepted. CLEANUP costs 1 cycle, absorbed by the sampling margin.
- o_Busy rises 1 cycle after `sync` falls and drops on entry to IDLE.

## Test plan
- CLKS_PER_BIT = 16, defaults (8N1). Send 0xA5 with an ideal waveform -> one DV, o_Rx_Byte = 0xA5, both flags 0, DV timing within ±1 of the formula.
- DATA_BITS = 7, PARITY = 2 (even), STOP_BITS = 2. Send 0x55 with correct parity, then 0x55 with parity flipped -> o_Parity_Err = 0, then 1. Data = 0x55 both times.
- Set stop bit = 0, then hold the line low for 40 bit times -> single DV with o_Frame_Err = 1. FSM waits in WAIT_HIGH; no further DV until the line returns high.
- Start-bit glitch of 5 cycles (< H) -> no DV, FSM back in IDLE. A single-cycle low glitch at mid-data-bit of 0xFF -> majority vote yields 0xFF.
- Two frames 0x3C, 0xC3 back-to-back with no idle gap -> two DVs, correct bytes, no errors.
- Assert i_Reset asynchronously mid-data-bit -> all outputs return to reset values immediately. The next clean frame, 0x81, is received correctly.
